// File: rtl/reg_writeback_ctrl_if.sv
// Result-source, register-file write-port and operand-fetch bundle for reg_writeback_ctrl.
// "master" is the surrounding pipeline side; "slave" is the writeback controller itself.
interface reg_writeback_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic                  res_valid;
  logic                  res_ready;
  logic [ADDR_W-1:0]     res_dest;
  logic [DATA_W-1:0]     res_data;
  logic                  wb_hold;
  logic                  enable_write;
  logic [ADDR_W-1:0]     write_to;
  logic [DATA_W-1:0]     data_in;
  logic [ADDR_W-1:0]     rd_addr1;
  logic [ADDR_W-1:0]     rd_addr2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
  logic [DATA_W-1:0]     fwd_data1;
  logic [DATA_W-1:0]     fwd_data2;
  logic [2**ADDR_W-1:0]  pending;

  modport master (
    output res_valid, res_dest, res_data, wb_hold, rd_addr1, rd_addr2,
    input  res_ready, enable_write, write_to, data_in,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, pending
  );

  modport slave (
    input  res_valid, res_dest, res_data, wb_hold, rd_addr1, rd_addr2,
    output res_ready, enable_write, write_to, data_in,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, pending
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// In-order writeback FIFO draining one result per cycle into the register file,
// with per-register pending bits and youngest-entry forwarding for operand fetch.
module reg_writeback_ctrl #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 n_reset,
  reg_writeback_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic push;
  logic pop;

  // Readiness looks only at registered occupancy, so a full FIFO refuses a
  // push even on the edge where the head drains.
  assign bus.res_ready = (count != CNT_W'(DEPTH));
  assign push          = bus.res_valid && bus.res_ready;
  assign pop           = (count != '0) && !bus.wb_hold;

  assign bus.enable_write = pop;
  assign bus.write_to     = pop ? dest_q[rd_ptr] : '0;
  assign bus.data_in      = pop ? data_q[rd_ptr] : '0;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop)  valid_q[rd_ptr] <= 1'b0;
      if (push) valid_q[wr_ptr] <= 1'b1;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: the payload array has no reset; valid_q alone decides whether an
  // entry is live, so stale contents are never observed and the storage stays
  // plain flops without a reset tree.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr] <= bus.res_dest;
      data_q[wr_ptr] <= bus.res_data;
    end
  end

  // Walk oldest to youngest so a later match overwrites an earlier one and the
  // youngest queued value wins.
  logic [PTR_W-1:0]  idx;
  logic [NREG-1:0]   pend;
  logic              hit1, hit2;
  logic [DATA_W-1:0] fdata1, fdata2;

  always_comb begin
    // NOTE: combinational logic uses blocking assignments, and every variable
    // gets a default before the loop so no path leaves it unassigned (no latch).
    idx    = '0;
    pend   = '0;
    hit1   = 1'b0;
    hit2   = 1'b0;
    fdata1 = '0;
    fdata2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid_q[idx]) begin
        pend[dest_q[idx]] = 1'b1;
        if (dest_q[idx] == bus.rd_addr1) begin
          hit1   = 1'b1;
          fdata1 = data_q[idx];
        end
        if (dest_q[idx] == bus.rd_addr2) begin
          hit2   = 1'b1;
          fdata2 = data_q[idx];
        end
      end
    end
  end

  assign bus.pending   = pend;
  assign bus.fwd_hit1  = hit1;
  assign bus.fwd_hit2  = hit2;
  assign bus.fwd_data1 = fdata1;
  assign bus.fwd_data2 = fdata2;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl (DEPTH=2): single write, fill under hold,
// full push+pop, youngest forwarding, streaming and asynchronous reset.
module tb_reg_writeback_ctrl;

  logic clk;
  logic n_reset;
  int   n_cmp;
  int   n_err;

  reg_writeback_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  reg_writeback_ctrl #(.DEPTH(2), .DATA_W(8), .ADDR_W(3)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [2:0] d, input logic [7:0] x);
    bus.res_valid = v;
    bus.res_dest  = d;
    bus.res_data  = x;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [2:0] a, input logic [7:0] x);
    check({tag, ".en"},   bus.enable_write, en);
    check({tag, ".addr"}, bus.write_to, a);
    check({tag, ".data"}, bus.data_in, x);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_reset = 1'b0;
    offer(1'b0, 3'd0, 8'h00);
    bus.wb_hold  = 1'b0;
    bus.rd_addr1 = 3'd0;
    bus.rd_addr2 = 3'd0;

    // Reset state
    #2;
    check("rst.ready", bus.res_ready, 1);
    check_wr("rst", 1'b0, 3'd0, 8'h00);
    check("rst.pending", bus.pending, 8'h00);
    check("rst.hit1", bus.fwd_hit1, 0);
    check("rst.fdata1", bus.fwd_data1, 0);
    @(negedge clk);
    n_reset = 1'b1;
    step();

    // Single write, 1-cycle latency; head still forwards while being written
    offer(1'b1, 3'd3, 8'h5A);
    bus.rd_addr1 = 3'd3;
    step();
    offer(1'b0, 3'd0, 8'h00);
    #1;
    check_wr("single", 1'b1, 3'd3, 8'h5A);
    check("single.pending", bus.pending, 8'h08);
    check("single.hit1", bus.fwd_hit1, 1);
    check("single.fdata1", bus.fwd_data1, 8'h5A);
    step();
    check("single.done_en", bus.enable_write, 0);
    check("single.done_pend", bus.pending, 8'h00);

    // Fill under hold, third offer rejected
    bus.wb_hold = 1'b1;
    offer(1'b1, 3'd1, 8'h11);
    step();
    offer(1'b1, 3'd2, 8'h22);
    step();
    offer(1'b1, 3'd4, 8'h44);
    #1;
    check("fill.ready", bus.res_ready, 0);
    check("fill.pending", bus.pending, 8'h06);
    check("fill.hold_en", bus.enable_write, 0);
    step();
    check("fill.rejected", bus.pending, 8'h06);
    check("fill.ready2", bus.res_ready, 0);

    // Release hold while full: pop happens, push stays blocked that edge
    bus.wb_hold = 1'b0;
    #1;
    check_wr("drain1", 1'b1, 3'd1, 8'h11);
    check("drain1.ready", bus.res_ready, 0);
    step();
    check_wr("drain2", 1'b1, 3'd2, 8'h22);
    check("drain2.ready", bus.res_ready, 1);
    check("drain2.pending", bus.pending, 8'h04);
    step();
    offer(1'b0, 3'd0, 8'h00);
    #1;
    check_wr("drain3", 1'b1, 3'd4, 8'h44);
    check("drain3.pending", bus.pending, 8'h10);
    step();
    check("drain.empty", bus.enable_write, 0);

    // Forwarding picks the youngest of two matches
    bus.wb_hold  = 1'b1;
    bus.rd_addr1 = 3'd5;
    bus.rd_addr2 = 3'd6;
    offer(1'b1, 3'd5, 8'hA0);
    step();
    offer(1'b1, 3'd5, 8'hB0);
    step();
    offer(1'b0, 3'd0, 8'h00);
    #1;
    check("fwd.hit1", bus.fwd_hit1, 1);
    check("fwd.data1", bus.fwd_data1, 8'hB0);
    check("fwd.hit2", bus.fwd_hit2, 0);
    check("fwd.data2", bus.fwd_data2, 8'h00);
    check("fwd.pending", bus.pending, 8'h20);
    bus.wb_hold = 1'b0;
    #1;
    check_wr("fwd.wr1", 1'b1, 3'd5, 8'hA0);
    check("fwd.data1_drain", bus.fwd_data1, 8'hB0);
    step();
    check_wr("fwd.wr2", 1'b1, 3'd5, 8'hB0);
    step();
    check("fwd.hit1_empty", bus.fwd_hit1, 0);
    check("fwd.data1_empty", bus.fwd_data1, 8'h00);

    // Streaming: one write per cycle, ready never drops
    for (int i = 0; i < 16; i++) begin
      offer(1'b1, 3'(i % 8), 8'(i));
      #1;
      check("stream.ready", bus.res_ready, 1);
      if (i > 0) check_wr("stream", 1'b1, 3'((i - 1) % 8), 8'(i - 1));
      step();
    end
    offer(1'b0, 3'd0, 8'h00);
    #1;
    check_wr("stream.last", 1'b1, 3'd7, 8'h0F);
    step();
    check("stream.empty", bus.enable_write, 0);

    // Asynchronous reset discards queued entries
    bus.wb_hold  = 1'b1;
    bus.rd_addr1 = 3'd6;
    offer(1'b1, 3'd6, 8'h66);
    step();
    offer(1'b1, 3'd7, 8'h77);
    step();
    offer(1'b0, 3'd0, 8'h00);
    #1;
    check("arst.pre_pending", bus.pending, 8'hC0);
    #2;
    n_reset = 1'b0;
    #1;
    check("arst.en", bus.enable_write, 0);
    check("arst.pending", bus.pending, 8'h00);
    check("arst.hit1", bus.fwd_hit1, 0);
    check("arst.ready", bus.res_ready, 1);
    bus.wb_hold = 1'b0;
    #2;
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst.no_write", bus.enable_write, 0);
      check("arst.no_pending", bus.pending, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Writeback sequencer between the execute/load result sources and the 8x8 register file write port.
- Buffers completed results in a small in-order FIFO and drains one entry per cycle into the register file.
- Exports per-register pending bits for hazard detection.
- Exports forwarding data so operand fetch can read values that are queued but not yet written.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, 2..4.
- DATA_W, 8, result and register data width.
- ADDR_W, 3, register address width; register count is 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- res_valid  input  1  result source presents an entry.
- res_ready  output  1  FIFO can accept an entry this cycle.
- res_dest  input  ADDR_W  destination register of the offered entry.
- res_data  input  DATA_W  value of the offered entry.
- wb_hold  input  1  when high, suppress draining (freeze/debug).
- enable_write  output  1  register file write enable.
- write_to  output  ADDR_W  register file write address.
- data_in  output  DATA_W  register file write data.
- rd_addr1  input  ADDR_W  operand fetch read address 1.
- rd_addr2  input  ADDR_W  operand fetch read address 2.
- fwd_hit1  output  1  a queued entry targets rd_addr1.
- fwd_hit2  output  1  a queued entry targets rd_addr2.
- fwd_data1  output  DATA_W  youngest queued value for rd_addr1; 0 when no hit.
- fwd_data2  output  DATA_W  youngest queued value for rd_addr2; 0 when no hit.
- pending  output  2**ADDR_W  bit r set when any valid entry targets register r.

Behaviour:
- State:
  - Circular FIFO of DEPTH entries {dest, data}, each with a valid bit.
  - Write pointer, read pointer, occupancy count (0..DEPTH).
- Reset (asynchronous, n_reset low):
  - Pointers and count go to 0; all valid bits clear.
  - res_ready=1, enable_write=0, write_to=0, data_in=0, pending=0, fwd_hit*=0, fwd_data*=0.
  - Entries queued at reset are discarded and never written.
- Push:
  - res_ready = (count != DEPTH), combinational from state only; it never depends on the same-cycle pop.
  - An entry is accepted at the rising edge where res_valid && res_ready.
  - res_valid while res_ready=0 has no effect; the source must hold the entry.
- Drain:
  - enable_write = (count != 0) && !wb_hold, combinational.
  - When enable_write=1, write_to/data_in equal the head entry; otherwise both are 0.
  - The head pops at the same rising edge the register file samples the write.
- Latency: an entry accepted at edge N is driven to the register file during cycle N..N+1 and written at edge N+1 at the earliest, with no hold and an empty FIFO.
- Throughput: one write per cycle sustained while the source keeps the FIFO non-full.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance, wrapping modulo DEPTH.
  - When full, push is blocked that cycle even though a pop occurs.
- Ordering:
  - Strictly in order.
  - Multiple entries to the same register are all written in arrival order; no coalescing.
- pending and forwarding:
  - Both are combinational from valid FIFO entries only; the offered-but-unaccepted res_* entry is excluded.
  - On multiple matches, fwd_data selects the youngest entry (closest to the write pointer).
  - The head entry counts as a match during the cycle it is being written.
- wb_hold:
  - Holds the FIFO contents; pushes continue until full.
  - Deasserting hold resumes draining the next cycle.
- Register 0 is an ordinary register here; no special-casing.

Test Plan:
- Single write: reset, push dest=3 data=0x5A, wb_hold=0 -> next cycle enable_write=1, write_to=3, data_in=0x5A, pending=0x08; following cycle enable_write=0, pending=0.
- Fill under hold: wb_hold=1, push (1,0x11) then (2,0x22) -> res_ready=0 after 2nd edge, pending=0x06; a third offer (4,0x44) is not accepted. Release hold -> writes (1,0x11) then (2,0x22) on consecutive edges, then accepts (4,0x44).
- Forwarding youngest: hold=1, push (5,0xA0) then (5,0xB0), rd_addr1=5, rd_addr2=6 -> fwd_hit1=1, fwd_data1=0xB0, fwd_hit2=0, fwd_data2=0.
- Streaming: res_valid=1 every cycle with dest=i%8, data=i for i=0..15, hold=0 -> 16 writes in order, one per cycle after 1-cycle latency, res_ready never 0.
- Full push+pop: DEPTH=2 full, hold released while offering (7,0x77) -> that edge pops head, push rejected (res_ready=0); the next edge accepts it.
- Reset mid-operation: two entries queued under hold, pulse n_reset low between edges -> enable_write, pending, fwd_hit* go 0 immediately; after release, no writes occur.
